// File: rtl/sha256_pkg.sv
// Shared SHA-256 widths, FSM state encoding, round constants and the
// sigma helper functions used by the padding front end and the core.
package sha256_pkg;

  localparam int BLOCK_W     = 512;
  localparam int DIGEST_W    = 256;
  localparam int LEN_FIELD_W = 64;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_e;

  localparam logic [DIGEST_W-1:0] SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round 0 constant sits at index 63, so round r reads SHA_K[63-r].
  localparam logic [63:0][31:0] SHA_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bigSigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bigSigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] smallSigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallSigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256.sv
// Iterative SHA-256 compression core, one round per clock. new_hash_i starts
// from the IV; otherwise the previous digest is the chaining value.
module sha256
  import sha256_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [BLOCK_W-1:0]  block_i,
  input  logic                new_hash_i,
  output logic [DIGEST_W-1:0] digest_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  typedef enum logic [1:0] {C_IDLE, C_RUN, C_OUT} core_state_e;

  core_state_e         state_q;
  logic [5:0]          round_q;
  logic [DIGEST_W-1:0] hash_q, work_q, workNext, hashSum;
  logic [15:0][31:0]   sched_q;
  logic [31:0]         wNew, a, b, c, d, e, f, g, h, t1, t2;

  // sched_q[15] is the word consumed this round; the window shifts toward it.
  always_comb begin
    {a, b, c, d, e, f, g, h} = work_q;
    t1 = h + bigSigma1(e) + ((e & f) ^ (~e & g)) + SHA_K[6'd63 - round_q] + sched_q[15];
    t2 = bigSigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    workNext = {t1 + t2, a, b, c, d + t1, e, f, g};
    wNew = smallSigma1(sched_q[1]) + sched_q[6] + smallSigma0(sched_q[14]) + sched_q[15];
    for (int i = 0; i < 8; i++)
      hashSum[32*i +: 32] = hash_q[32*i +: 32] + workNext[32*i +: 32];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= C_IDLE;
      round_q <= '0;
      hash_q  <= '0;
      work_q  <= '0;
      sched_q <= '0;
    end else begin
      case (state_q)
        C_IDLE: if (in_valid_i) begin
          sched_q <= block_i;
          work_q  <= new_hash_i ? SHA_IV : hash_q;
          if (new_hash_i) hash_q <= SHA_IV;
          round_q <= '0;
          state_q <= C_RUN;
        end
        C_RUN: begin
          work_q  <= workNext;
          sched_q <= {sched_q[14:0], wNew};
          round_q <= round_q + 6'd1;
          if (round_q == 6'd63) begin
            hash_q  <= hashSum;
            state_q <= C_OUT;
          end
        end
        C_OUT: if (out_ready_i) state_q <= C_IDLE;
        default: state_q <= C_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == C_IDLE);
  assign out_valid_o = (state_q == C_OUT);
  assign digest_o    = hash_q;

endmodule

// File: rtl/sha256_pad.sv
// Combinational padding: masks bytes past len, appends 0x80 and the 64-bit
// bit length at the end of the last used block, and reports the block count.
module sha256_pad
  import sha256_pkg::*;
#(
  parameter int MAX_BLOCKS = 2,
  parameter int MSG_W      = MAX_BLOCKS * BLOCK_W,
  parameter int LEN_W      = $clog2(MAX_BLOCKS * 64 + 1),
  parameter int CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
  input  logic [MSG_W-1:0] msg_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [MSG_W-1:0] padded_o,
  output logic [CNT_W-1:0] nb_o,
  output logic             too_long_o
);

  localparam int MAX_LEN   = MAX_BLOCKS * 64 - 9;
  localparam int NUM_BYTES = MSG_W / 8;

  logic [LEN_FIELD_W-1:0] lenBits;
  int lenInt;
  int nbInt;
  int fieldStart;

  always_comb begin
    lenInt     = int'(len_i);
    nbInt      = (lenInt + 8) / 64 + 1;
    fieldStart = nbInt * 64 - 8;
    too_long_o = lenInt > MAX_LEN;
    nb_o       = CNT_W'(nbInt);
    lenBits    = LEN_FIELD_W'(len_i) << 3;
    padded_o   = '0;
    // An over-long message never reaches the core, so the length field is skipped.
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (i < lenInt)
        padded_o[MSG_W-1-8*i -: 8] = msg_i[MSG_W-1-8*i -: 8];
      else if (i == lenInt)
        padded_o[MSG_W-1-8*i -: 8] = 8'h80;
      else if (!too_long_o && i >= fieldStart && i < fieldStart + 8)
        padded_o[MSG_W-1-8*i -: 8] = lenBits[LEN_FIELD_W-1-8*(i-fieldStart) -: 8];
    end
  end

endmodule

// File: rtl/sha256_multiblock.sv
// Multi-block SHA-256 front end: pads a length-tagged message and streams its
// blocks through one sha256 core, chaining state, returning a single digest.
module sha256_multiblock
  import sha256_pkg::*;
#(
  parameter int MAX_BLOCKS = 2,
  parameter int MSG_W      = MAX_BLOCKS * BLOCK_W,
  parameter int LEN_W      = $clog2(MAX_BLOCKS * 64 + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [MSG_W-1:0]    msg_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [DIGEST_W-1:0] out_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                err_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(MAX_BLOCKS + 1);

  state_e              state_q;
  logic [MSG_W-1:0]    padded_d, padded_q;
  logic [CNT_W-1:0]    nb_d, nb_q, blk_q;
  logic                tooLong_d;
  logic [DIGEST_W-1:0] digest_q, coreDigest;
  logic                err_q, inReady_q, outValid_q, coreInValid_q;
  logic                coreInReady, coreNewHash, coreOutValid, coreOutReady;
  logic [BLOCK_W-1:0]  coreBlock;
  int                  blkOff;

  sha256_pad #(
    .MAX_BLOCKS(MAX_BLOCKS),
    .MSG_W     (MSG_W),
    .LEN_W     (LEN_W),
    .CNT_W     (CNT_W)
  ) u_pad (
    .msg_i     (msg_i),
    .len_i     (len_i),
    .padded_o  (padded_d),
    .nb_o      (nb_d),
    .too_long_o(tooLong_d)
  );

  always_comb begin
    blkOff    = BLOCK_W * int'(blk_q);
    coreBlock = padded_q[MSG_W-1-blkOff -: BLOCK_W];
  end

  assign coreNewHash  = (blk_q == '0);
  assign coreOutReady = (state_q == WAIT);

  sha256 u_core (
    .clk_i      (clk_i),
    .rst_i      (~rst_ni),
    .in_valid_i (coreInValid_q),
    .in_ready_o (coreInReady),
    .block_i    (coreBlock),
    .new_hash_i (coreNewHash),
    .digest_o   (coreDigest),
    .out_valid_o(coreOutValid),
    .out_ready_i(coreOutReady)
  );

  // The message is stored already padded, so only the block index moves.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      padded_q      <= '0;
      nb_q          <= '0;
      blk_q         <= '0;
      digest_q      <= '0;
      err_q         <= 1'b0;
      inReady_q     <= 1'b0;
      outValid_q    <= 1'b0;
      coreInValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          inReady_q <= 1'b1;
          if (in_valid_i && inReady_q) begin
            padded_q  <= padded_d;
            nb_q      <= nb_d;
            blk_q     <= '0;
            inReady_q <= 1'b0;
            if (tooLong_d) begin
              err_q      <= 1'b1;
              digest_q   <= '0;
              outValid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              coreInValid_q <= 1'b1;
              state_q       <= LOAD;
            end
          end
        end
        LOAD: if (coreInReady) begin
          coreInValid_q <= 1'b0;
          state_q       <= WAIT;
        end
        WAIT: if (coreOutValid) begin
          if (blk_q == nb_q - 1'b1) begin
            digest_q   <= coreDigest;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            blk_q         <= blk_q + 1'b1;
            coreInValid_q <= 1'b1;
            state_q       <= LOAD;
          end
        end
        DONE: if (out_ready_i) begin
          outValid_q <= 1'b0;
          err_q      <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = inReady_q;
  assign out_valid_o = outValid_q;
  assign out_o       = digest_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != IDLE);

endmodule
